// File: rtl/alu_pkg.sv
// Shared types for the 8-bit multi-cycle ALU and its host-side sequencer.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD1,
    HOLD,
    WAIT,
    RESP
  } host_state_e;

  // Divide takes the full A.Q dividend; the other ops use only the low byte.
  function automatic logic [2*ALU_W-1:0] operand1(
    input alu_op_e             op,
    input logic [2*ALU_W-1:0] a
  );
    return (op == OP_DIV) ? a : {{ALU_W{1'b0}}, a[ALU_W-1:0]};
  endfunction

endpackage

// File: rtl/alu_host_timer.sv
// Clearable WAIT-cycle counter; expired flags the last permitted WAIT cycle.
module alu_host_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = !clr && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_host.sv
// Host sequencer for the multi-cycle ALU: request in, load/wait, response out.
// Optional WAIT timeout abort is enabled by defining ALU_HOST_TIMEOUT_EN.
module alu_host
  import alu_pkg::*;
`ifdef ALU_HOST_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 64
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        alu_rst,
  output logic        alu_start,
  output logic [1:0]  alu_sel,
  output logic [15:0] alu_inbus,
  input  logic        alu_finish,
  input  logic [15:0] alu_outbus
);

  localparam int DW = 2 * ALU_W;

  host_state_e   state_q, state_d;
  alu_op_e       op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          start_q, start_d;
  logic [1:0]    sel_q, sel_d;
  logic [DW-1:0] inbus_q, inbus_d;
  logic          timeout;

`ifdef ALU_HOST_TIMEOUT_EN
  alu_host_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != WAIT),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = alu_op_e'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          state_d = CLR;
        end
      end
      CLR:   state_d = LOAD1;
      LOAD1: state_d = HOLD;
      HOLD:  state_d = WAIT;
      WAIT: begin
        if (alu_finish) begin
          data_d  = op_q[1] ? alu_outbus
                            : {8'h00, alu_outbus[7:0]};
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timeout) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they arrive registered.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    start_d     = (state_d == LOAD1);
    sel_d       = '0;
    inbus_d     = '0;
    unique case (1'b1)
      (state_d == LOAD1) || (state_d == HOLD): begin
        sel_d   = op_d;
        inbus_d = operand1(op_d, a_d);
      end
      (state_d == WAIT): begin
        sel_d   = op_d;
        inbus_d = {8'h00, b_d};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      start_q     <= 1'b0;
      sel_q       <= '0;
      inbus_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      start_q     <= start_d;
      sel_q       <= sel_d;
      inbus_q     <= inbus_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign alu_rst   = rst | (state_q == CLR);
  assign alu_start = start_q;
  assign alu_sel   = sel_q;
  assign alu_inbus = inbus_q;

endmodule
